regfile_write_arbiter: RTL and testbench



---
 rtl/regfile_write_arbiter_if.sv | 37 +++
 rtl/regfile_write_arbiter.sv | 110 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and the register file
// write port. The master side is the requester/register-file environment, the
// slave side is the arbiter.
interface regfile_write_arbiter_if #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_W    = 2
);
  logic                 req0_valid;
  logic [ADDR_W-1:0]    req0_addr;
  logic [WORD_SIZE-1:0] req0_data;
  logic                 req0_ready;

  logic                 req1_valid;
  logic [ADDR_W-1:0]    req1_addr;
  logic [WORD_SIZE-1:0] req1_data;
  logic                 req1_ready;

  logic                 rf_we;
  logic [ADDR_W-1:0]    rf_waddr;
  logic [WORD_SIZE-1:0] rf_wdata;

  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    output rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU
// (req0) and load (req1) writeback paths. The winner is captured into a
// one-entry commit stage that drives the write port on the following cycle.
// reset_n is asynchronous and active-high (asserted when 1).
module regfile_write_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_REGS  = 4,
  parameter int ADDR_W    = 2,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  regfile_write_arbiter_if.slave bus,
  output logic [NUM_REGS-1:0]  busy_mask,
  output logic [CNT_W-1:0]     commit_cnt0,
  output logic [CNT_W-1:0]     commit_cnt1
);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + CNT_W'(1);
  endfunction

  logic                 rr_q, rr_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    waddr_q, waddr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic                 src_q, src_d;
  logic [CNT_W-1:0]     cnt0_q, cnt0_d;
  logic [CNT_W-1:0]     cnt1_q, cnt1_d;
  logic                 gnt0, gnt1;

  // Grant: a lone requester always wins; on contention rr picks the winner.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset_n) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt0 = ~rr_q;
        gnt1 = rr_q;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  // The commit stage drains every cycle, so ready is simply the grant.
  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  // Next state: capture the winner, hand priority to the loser, count commits.
  always_comb begin
    rr_d    = rr_q;
    we_d    = gnt0 | gnt1;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    src_d   = src_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    if (gnt1) begin
      waddr_d = bus.req1_addr;
      wdata_d = bus.req1_data;
      src_d   = 1'b1;
      rr_d    = 1'b0;
    end else if (gnt0) begin
      waddr_d = bus.req0_addr;
      wdata_d = bus.req0_data;
      src_d   = 1'b0;
      rr_d    = 1'b1;
    end
    if (we_q && !src_q) cnt0_d = sat_inc(cnt0_q);
    if (we_q &&  src_q) cnt1_d = sat_inc(cnt1_q);
  end

  // State registers; reset clears the staged write so it never commits.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      rr_q    <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      src_q   <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      rr_q    <= rr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      src_q   <= src_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  // Busy mask: one-hot of the in-flight destination, empty when idle.
  always_comb begin
    busy_mask = '0;
    if (we_q) busy_mask[waddr_q] = 1'b1;
  end

  assign bus.rf_we    = we_q;
  assign bus.rf_waddr = waddr_q;
  assign bus.rf_wdata = wdata_q;
  assign commit_cnt0  = cnt0_q;
  assign commit_cnt1  = cnt1_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: table vectors, directed
// corner sequences, randomized traffic against a behavioural model, and a
// counter-saturation run on a narrow-counter instance.
module tb_regfile_write_arbiter;
  localparam int WS = 16;
  localparam int NR = 4;
  localparam int AW = 2;

  logic clk;
  logic reset_n;

  regfile_write_arbiter_if #(.WORD_SIZE(WS), .ADDR_W(AW)) bus1 ();
  regfile_write_arbiter_if #(.WORD_SIZE(WS), .ADDR_W(AW)) bus2 ();

  logic [NR-1:0] busy1, busy2;
  logic [15:0]   c0_1, c1_1;
  logic [3:0]    c0_2, c1_2;

  regfile_write_arbiter #(.WORD_SIZE(WS), .NUM_REGS(NR), .ADDR_W(AW), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave),
    .busy_mask(busy1), .commit_cnt0(c0_1), .commit_cnt1(c1_1));

  regfile_write_arbiter #(.WORD_SIZE(WS), .NUM_REGS(NR), .ADDR_W(AW), .CNT_W(4)) dut_sat (
    .clk(clk), .reset_n(reset_n), .bus(bus2.slave),
    .busy_mask(busy2), .commit_cnt0(c0_2), .commit_cnt1(c1_2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: who has priority, what the write port shows this
  // cycle, and how many writes each requester has committed.
  int m_prio;          // requester preferred on contention
  bit m_pend;          // a write is visible on the port this cycle
  int m_addr, m_data, m_src;
  int m_cnt[2];
  localparam int CMAX = 65535;

  task automatic model_clear();
    m_prio = 0; m_pend = 0; m_addr = 0; m_data = 0; m_src = 0;
    m_cnt[0] = 0; m_cnt[1] = 0;
  endtask

  // One clock cycle on dut: drive inputs, check everything against the
  // model, then advance the model across the rising edge.
  task automatic step(input bit v0, input int a0, input int d0,
                      input bit v1, input int a1, input int d1,
                      output logic r0, output logic r1);
    int g;
    bus1.req0_valid = v0; bus1.req0_addr = AW'(a0); bus1.req0_data = WS'(d0);
    bus1.req1_valid = v1; bus1.req1_addr = AW'(a1); bus1.req1_data = WS'(d1);
    #1;
    if (reset_n) begin
      model_clear();
      g = -1;
    end else if (v0 && v1) g = m_prio;
    else if (v0) g = 0;
    else if (v1) g = 1;
    else g = -1;
    r0 = bus1.req0_ready;
    r1 = bus1.req1_ready;
    chk("ready0", 32'(r0), 32'(g == 0));
    chk("ready1", 32'(r1), 32'(g == 1));
    chk("rf_we", 32'(bus1.rf_we), 32'(m_pend));
    chk("rf_waddr", 32'(bus1.rf_waddr), m_addr);
    chk("rf_wdata", 32'(bus1.rf_wdata), m_data);
    chk("busy_mask", 32'(busy1), m_pend ? (1 << m_addr) : 0);
    chk("commit_cnt0", 32'(c0_1), m_cnt[0]);
    chk("commit_cnt1", 32'(c1_1), m_cnt[1]);
    if (!reset_n) begin
      if (m_pend && m_cnt[m_src] < CMAX) m_cnt[m_src]++;
      if (g >= 0) begin
        m_pend = 1;
        m_addr = (g == 0) ? a0 : a1;
        m_data = (g == 0) ? d0 : d1;
        m_src  = g;
        m_prio = 1 - g;
      end else begin
        m_pend = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic r0, r1;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, r0, r1);
  endtask

  task automatic do_reset();
    reset_n = 1'b1;
    idle(2);
    reset_n = 1'b0;
  endtask

  typedef struct {
    bit v0; int a0; int d0;
    bit v1; int a1; int d1;
    bit e0; bit e1;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r0, r1;
    // Vectors from a freshly reset arbiter (req0 preferred).
    tbl[0] = '{1, 2, 'hBEEF, 0, 0, 0,      1, 0};
    tbl[1] = '{0, 0, 0,      0, 0, 0,      0, 0};
    tbl[2] = '{1, 1, 'h1111, 1, 3, 'h3333, 0, 1};
    tbl[3] = '{1, 0, 'h0A0A, 1, 2, 'h2B2B, 1, 0};
    tbl[4] = '{0, 1, 'hFFFF, 1, 1, 'h5151, 0, 1};
    tbl[5] = '{1, 3, 'hC3C3, 1, 0, 'hD0D0, 1, 0};

    bus2.req0_valid = 0; bus2.req0_addr = '0; bus2.req0_data = '0;
    bus2.req1_valid = 0; bus2.req1_addr = '0; bus2.req1_data = '0;
    model_clear();
    reset_n = 1'b0;
    #1 reset_n = 1'b1;

    // Reset held with both requesters valid: nothing may be granted.
    for (int i = 0; i < 3; i++) step(1, 1, 'h7777, 1, 2, 'h8888, r0, r1);
    reset_n = 1'b0;

    // Single requester write with exact latency and busy timing.
    step(1, 2, 'hBEEF, 0, 0, 0, r0, r1);
    chk("single_ready0", 32'(r0), 1);
    chk("single_we", 32'(bus1.rf_we), 1);
    chk("single_waddr", 32'(bus1.rf_waddr), 2);
    chk("single_wdata", 32'(bus1.rf_wdata), 'hBEEF);
    chk("single_busy", 32'(busy1), 4'b0100);
    idle(1);
    chk("single_busy_clear", 32'(busy1), 0);
    chk("single_cnt0", 32'(c0_1), 1);

    // Table vectors.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1, r0, r1);
      chk("tbl_ready0", 32'(r0), 32'(tbl[i].e0));
      chk("tbl_ready1", 32'(r1), 32'(tbl[i].e1));
    end
    idle(2);

    // Continuous contention alternates grants and commits every cycle.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 'h100 + i, 1, 3, 'h300 + i, r0, r1);
      chk("cont_ready0", 32'(r0), 32'(i % 2 == 0));
      chk("cont_ready1", 32'(r1), 32'(i % 2 == 1));
      chk("cont_we", 32'(bus1.rf_we), 1);
      chk("cont_waddr", 32'(bus1.rf_waddr), (i % 2 == 0) ? 1 : 3);
    end
    idle(2);
    chk("cont_cnt0", 32'(c0_1), 3);
    chk("cont_cnt1", 32'(c1_1), 3);

    // A lone req1 grant hands priority back to req0.
    step(0, 0, 0, 1, 2, 'h5555, r0, r1);
    chk("rot_first_ready1", 32'(r1), 1);
    step(1, 0, 'h6666, 1, 1, 'h7777, r0, r1);
    chk("rot_ready0", 32'(r0), 1);
    chk("rot_ready1", 32'(r1), 0);
    idle(2);

    // Reset arriving while a write is staged discards it.
    do_reset();
    step(0, 0, 0, 1, 0, 'h1234, r0, r1);
    chk("rst_mid_ready1", 32'(r1), 1);
    chk("rst_mid_staged_we", 32'(bus1.rf_we), 1);
    chk("rst_mid_staged_data", 32'(bus1.rf_wdata), 'h1234);
    reset_n = 1'b1;
    #1;
    chk("rst_mid_we", 32'(bus1.rf_we), 0);
    chk("rst_mid_wdata", 32'(bus1.rf_wdata), 0);
    chk("rst_mid_cnt1", 32'(c1_1), 0);
    idle(1);
    reset_n = 1'b0;
    idle(2);
    chk("rst_mid_cnt1_after", 32'(c1_1), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)),
           r0, r1);
    end
    idle(2);

    // Saturation on the 4-bit counter instance: 20 back-to-back req0 writes.
    bus2.req0_valid = 1; bus2.req0_addr = 2'd1; bus2.req0_data = 16'hA5A5;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 10) chk("sat_cnt_mid", 32'(c0_2), 9);
      if (k == 20) chk("sat_cnt_top", 32'(c0_2), 15);
    end
    bus2.req0_valid = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
    end
    chk("sat_cnt_hold", 32'(c0_2), 15);
    chk("sat_cnt1", 32'(c1_2), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
